// File: rtl/lcd_cmd_sequencer.sv
// Write-only sequencer for an HD44780-type 16x2 LCD on an 8-bit bus: runs the
// fixed init sequence after power-on delay, then serves single-byte writes.
module lcd_cmd_sequencer #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 12,
  parameter int unsigned T_SHORT = 2000,
  parameter int unsigned T_LONG  = 82000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iSTART,
  input  logic       iVALID,
  input  logic       iRS,
  input  logic [7:0] iDATA,
  output logic       oREADY,
  output logic       oINIT_DONE,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic       oLCD_EN,
  output logic [7:0] oLCD_DATA
);

  localparam int unsigned T_MAX_A = (T_LONG > T_SHORT) ? T_LONG : T_SHORT;
  localparam int unsigned T_MAX_B = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int unsigned TW      = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_WAIT,
    S_READY
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [1:0]      idx_q, idx_d;
  logic            done_q, done_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            en_q;
  logic            ready_q;
  logic            long_wait;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    init_rom = 8'h38;
      2'd1:    init_rom = 8'h0C;
      2'd2:    init_rom = 8'h01;
      default: init_rom = 8'h06;
    endcase
  endfunction

  // Clear and home need the long execution wait; everything else is short.
  assign long_wait = !rs_q && (data_q == 8'h01 || data_q == 8'h02);

  // The setup phase spans the latch cycle plus T_SETUP, hence a load of
  // T_SETUP rather than T_SETUP-1.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    done_d  = done_q;
    rs_d    = rs_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (iSTART) begin
          idx_d   = 2'd0;
          rs_d    = 1'b0;
          data_d  = init_rom(2'd0);
          timer_d = TW'(T_SETUP);
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (timer_q == '0) begin
          timer_d = TW'(T_PULSE - 1);
          state_d = S_PULSE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_PULSE: begin
        if (timer_q == '0) begin
          timer_d = long_wait ? TW'(T_LONG - 1) : TW'(T_SHORT - 1);
          state_d = S_WAIT;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (!done_q && idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          rs_d    = 1'b0;
          data_d  = init_rom(idx_q + 2'd1);
          timer_d = TW'(T_SETUP);
          state_d = S_SETUP;
        end else begin
          done_d  = 1'b1;
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (iVALID) begin
          rs_d    = iRS;
          data_d  = iDATA;
          timer_d = TW'(T_SETUP);
          state_d = S_SETUP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // EN and READY are registered from the next state so the pins never glitch.
  always_ff @(posedge iCLK or posedge iRST) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (iRST) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= 2'd0;
      done_q  <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      en_q    <= (state_d == S_PULSE);
      ready_q <= (state_d == S_READY);
    end
  end

  assign oREADY     = ready_q;
  assign oINIT_DONE = done_q;
  assign oLCD_RS    = rs_q;
  assign oLCD_RW    = 1'b0;
  assign oLCD_EN    = en_q;
  assign oLCD_DATA  = data_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Self-checking bench for lcd_cmd_sequencer: EN-pulse monitor plus a timing
// model derived from the setup/pulse/wait rules, with randomized writes.
module tb_lcd_cmd_sequencer;

  localparam int S  = 2;
  localparam int P  = 4;
  localparam int SH = 10;
  localparam int LG = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic       rs = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, init_done, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;

  lcd_cmd_sequencer #(.T_SETUP(S), .T_PULSE(P), .T_SHORT(SH), .T_LONG(LG)) dut (
    .iCLK(clk), .iRST(rst), .iSTART(start), .iVALID(valid), .iRS(rs), .iDATA(data),
    .oREADY(ready), .oINIT_DONE(init_done), .oLCD_RS(lcd_rs), .oLCD_RW(lcd_rw),
    .oLCD_EN(lcd_en), .oLCD_DATA(lcd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         start;
    int         len;
    logic       rs;
    logic [7:0] data;
  } pulse_t;

  typedef struct {
    int         k;
    logic       rs;
    logic [7:0] data;
  } xfer_t;

  pulse_t pulses[$];
  pulse_t cur;
  logic   en_prev = 1'b0;

  // Pulse recorder: each EN high interval becomes one entry; bus must hold still.
  always @(negedge clk) begin
    if (lcd_rw !== 1'b0) begin
      errors++;
      $display("FAIL rw_const: got %b want 0 at cycle %0d", lcd_rw, cyc);
    end
    if (lcd_en && !en_prev) begin
      cur.start = cyc;
      cur.rs    = lcd_rs;
      cur.data  = lcd_data;
    end else if (lcd_en && en_prev) begin
      if (lcd_rs !== cur.rs || lcd_data !== cur.data) begin
        errors++;
        $display("FAIL bus_stable: got rs=%b data=%h want rs=%b data=%h at cycle %0d",
                 lcd_rs, lcd_data, cur.rs, cur.data, cyc);
      end
    end else if (!lcd_en && en_prev) begin
      cur.len = cyc - cur.start;
      pulses.push_back(cur);
    end
    en_prev = lcd_en;
  end

  function automatic int wait_of(input logic r, input logic [7:0] d);
    return (!r && (d == 8'h01 || d == 8'h02)) ? LG : SH;
  endfunction

  task automatic check_pulse(input string name, input int idx, input int exp_start,
                             input logic exp_rs, input logic [7:0] exp_data);
    checks++;
    if (pulses.size() <= idx) begin
      errors++;
      $display("FAIL %s: pulse %0d missing, got %0d pulses", name, idx, pulses.size());
    end else if (pulses[idx].start !== exp_start || pulses[idx].len !== P ||
                 pulses[idx].rs !== exp_rs || pulses[idx].data !== exp_data) begin
      errors++;
      $display("FAIL %s: got start=%0d len=%0d rs=%b data=%h want start=%0d len=%0d rs=%b data=%h",
               name, pulses[idx].start, pulses[idx].len, pulses[idx].rs, pulses[idx].data,
               exp_start, P, exp_rs, exp_data);
    end
  endtask

  // All tasks below are entered and left 1 time unit after a rising edge.
  task automatic wait_ready(output int r, input int budget);
    r = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        r = cyc;
        break;
      end
    end
    checks++;
    if (r < 0) begin
      errors++;
      $display("FAIL ready_timeout: got no ready within %0d cycles want ready", budget);
    end
  endtask

  task automatic do_write(input logic w_rs, input logic [7:0] w_data, output int k);
    valid = 1'b1;
    rs    = w_rs;
    data  = w_data;
    k     = -1;
    for (int i = 0; i < 200; i++) begin
      if (ready) begin
        @(posedge clk); #1;
        k = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    valid = 1'b0;
    checks++;
    if (k < 0) begin
      errors++;
      $display("FAIL handshake_timeout: got no handshake want one");
    end
  endtask

  task automatic check_write(input string name, input logic w_rs, input logic [7:0] w_data);
    int k, r, w;
    pulses.delete();
    do_write(w_rs, w_data, k);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready_drop: got %b want 0", name, ready);
    end
    wait_ready(r, 200);
    w = wait_of(w_rs, w_data);
    checks++;
    if (r !== k + S + P + w + 1) begin
      errors++;
      $display("FAIL %s_ready_return: got cycle %0d want %0d", name, r, k + S + P + w + 1);
    end
    check_pulse(name, 0, k + S + 1, w_rs, w_data);
    checks++;
    if (pulses.size() !== 1) begin
      errors++;
      $display("FAIL %s_pulse_count: got %0d want 1", name, pulses.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ready, init_done, lcd_rs, lcd_rw, lcd_en, lcd_data} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {ready, init_done, lcd_rs, lcd_rw, lcd_en, lcd_data});
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    logic bad = 1'b0;
    pulses.delete();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (lcd_en || ready || init_done) bad = 1'b1;
    end
    checks++;
    if (bad || pulses.size() != 0) begin
      errors++;
      $display("FAIL idle_quiet: got activity=%b pulses=%0d want 0 0", bad, pulses.size());
    end
  endtask

  task automatic test_init();
    logic [7:0] rom [4];
    int k, f, d;
    rom[0] = 8'h38; rom[1] = 8'h0C; rom[2] = 8'h01; rom[3] = 8'h06;
    pulses.delete();
    valid = 1'b1;                      // must be ignored throughout init
    rs    = 1'b1;
    data  = 8'h55;
    start = 1'b1;
    k = cyc + 1;
    d = -1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (init_done) begin
        d = cyc;
        break;
      end
    end
    valid = 1'b0;
    start = 1'b0;                      // falling start after init has no effect
    for (int i = 0; i < 4; i++) begin
      check_pulse($sformatf("init_byte%0d", i), i, k + S + 1, 1'b0, rom[i]);
      f = k + S + 1 + P;
      k = f + wait_of(1'b0, rom[i]);
    end
    checks++;
    if (d !== k || ready !== 1'b1) begin
      errors++;
      $display("FAIL init_done_time: got cycle %0d ready=%b want cycle %0d ready=1", d, ready, k);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (pulses.size() !== 4 || init_done !== 1'b1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL init_settle: got pulses=%0d done=%b ready=%b want 4 1 1",
               pulses.size(), init_done, ready);
    end
  endtask

  task automatic test_char();
    check_write("char_41", 1'b1, 8'h41);
  endtask

  task automatic test_long_wait();
    check_write("clear_long", 1'b0, 8'h01);
    check_write("home_long", 1'b0, 8'h02);
    check_write("data01_short", 1'b1, 8'h01);
  endtask

  task automatic test_random_writes();
    logic       r;
    logic [7:0] d;
    for (int i = 0; i < 6; i++) begin
      r = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom);
      check_write($sformatf("rand%0d", i), r, d);
    end
  endtask

  task automatic test_back_to_back();
    xfer_t exp[$];
    int r, w, n;
    pulses.delete();
    valid = 1'b1;
    for (int i = 0; i < 400 && exp.size() < 4; i++) begin
      rs   = 1'($urandom_range(0, 1));
      data = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'($urandom);
      if (ready) exp.push_back('{cyc + 1, rs, data});
      @(posedge clk); #1;
    end
    valid = 1'b0;
    n = exp.size();
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d handshakes want 4", n);
    end
    wait_ready(r, 200);
    for (int i = 0; i < n; i++) begin
      check_pulse($sformatf("b2b%0d", i), i, exp[i].k + S + 1, exp[i].rs, exp[i].data);
      if (i > 0) begin
        w = wait_of(exp[i-1].rs, exp[i-1].data);
        checks++;
        if (exp[i].k != exp[i-1].k + S + P + w + 2) begin
          errors++;
          $display("FAIL b2b_spacing%0d: got edge %0d want %0d", i, exp[i].k,
                   exp[i-1].k + S + P + w + 2);
        end
      end
    end
    if (n > 0) begin
      w = wait_of(exp[n-1].rs, exp[n-1].data);
      checks++;
      if (r !== exp[n-1].k + S + P + w + 1) begin
        errors++;
        $display("FAIL b2b_ready_return: got cycle %0d want %0d", r, exp[n-1].k + S + P + w + 1);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    int j, got;
    rst = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b1;
    pulses.delete();
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (pulses.size() == 1 && lcd_en) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got || lcd_data !== 8'h0C) begin
      errors++;
      $display("FAIL rst_precond: got in_pulse=%0d data=%h want 1 0c", got, lcd_data);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({ready, init_done, lcd_rs, lcd_rw, lcd_en, lcd_data} !== 13'h0) begin
      errors++;
      $display("FAIL rst_async: got %h want 0", {ready, init_done, lcd_rs, lcd_rw, lcd_en, lcd_data});
    end
    @(posedge clk); #1;
    pulses.delete();
    rst = 1'b0;
    j = cyc;
    for (int i = 0; i < 100 && pulses.size() == 0; i++) begin
      @(posedge clk); #1;
    end
    check_pulse("rst_restart", 0, j + 1 + S + 1, 1'b0, 8'h38);
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_init();
    test_char();
    test_long_wait();
    test_back_to_back();
    test_random_writes();
    test_reset_mid_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
